// File: rtl/lib_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : lib_cpu (package)
//  Purpose  : Shared types and sizes for the 4-bit CPU program-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
package lib_cpu;

    // Loader / run-controller states; order fixes the debug encoding
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } LDR_STATE;

    localparam int PROG_DEPTH = 16;
    localparam int PROG_WIDTH = 8;
    localparam int PROG_AW    = $clog2(PROG_DEPTH);

endpackage
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mem
//  Purpose  : 16x8 instruction store. One synchronous write port, one
//             asynchronous read port, whole array cleared by reset.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_mem
    import lib_cpu::*;
(
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  we,
    input  logic [PROG_AW-1:0]    waddr,
    input  logic [PROG_WIDTH-1:0] wdata,
    input  logic [PROG_AW-1:0]    raddr,
    output logic [PROG_WIDTH-1:0] rdata
);

    logic [PROG_WIDTH-1:0] mem [PROG_DEPTH];

    // Write port; reset wipes the array so a partial program never survives
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch port is a plain mux so the CPU sees data in the same cycle
    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Owns the CPU program memory and sequences the core through
//             load, halt, free-run and single-step using its reset and a
//             clock-enable tick.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader
    import lib_cpu::*;
#(
    parameter int PRESCALE = 4
)
(
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  load_start,
    input  logic                  wr_valid,
    input  logic [PROG_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  run_en,
    input  logic                  step,
    input  logic [PROG_AW-1:0]    cpu_addr,
    output logic [PROG_WIDTH-1:0] cpu_data,
    output logic                  cpu_n_reset,
    output logic                  cpu_tick,
    output logic                  load_done,
    output logic [1:0]            state
);

    // Prescale counter is sized for the largest legal PRESCALE (256)
    localparam logic [7:0] CNT_LAST = 8'(PRESCALE - 1);

    LDR_STATE             cur_state;
    logic [PROG_AW-1:0]   wptr;
    logic [7:0]           pcnt;
    logic                 wr_fire;

    // A restart cycle must never accept a byte, hence the load_start mask
    assign wr_ready = (cur_state == LOAD) && !load_start;
    assign wr_fire  = wr_valid && wr_ready;
    assign state    = cur_state;

    prog_mem u_prog_mem (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (wr_fire),
        .waddr   (wptr),
        .wdata   (wr_data),
        .raddr   (cpu_addr),
        .rdata   (cpu_data)
    );

    // Run-control FSM with write pointer, prescaler and registered outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cur_state   <= HALT;
            wptr        <= '0;
            pcnt        <= '0;
            cpu_n_reset <= 1'b0;
            cpu_tick    <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            cpu_tick  <= 1'b0;
            load_done <= 1'b0;
            if (load_start) begin
                // Restart wins over everything and holds the core in reset
                cur_state   <= LOAD;
                wptr        <= '0;
                pcnt        <= '0;
                cpu_n_reset <= 1'b0;
            end else begin
                case (cur_state)
                    LOAD: begin
                        if (wr_fire) begin
                            wptr <= wptr + 1'b1;  // wraps to 0 after 15
                            if (wptr == PROG_AW'(PROG_DEPTH - 1)) begin
                                cur_state   <= HALT;
                                load_done   <= 1'b1;
                                cpu_n_reset <= 1'b1;
                            end
                        end
                    end
                    HALT: begin
                        // run_en has priority over a coincident step
                        if (run_en) begin
                            cur_state   <= RUN;
                            pcnt        <= '0;
                            cpu_n_reset <= 1'b1;
                        end else if (step) begin
                            cur_state   <= STEP;
                            cpu_tick    <= 1'b1;
                            cpu_n_reset <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A tick due this cycle still fires even if run_en drops
                        if (pcnt == CNT_LAST) begin
                            pcnt     <= '0;
                            cpu_tick <= 1'b1;
                        end else begin
                            pcnt <= pcnt + 8'd1;
                        end
                        if (!run_en) begin
                            cur_state <= HALT;
                        end
                    end
                    STEP: begin
                        cur_state <= HALT;
                    end
                    default: begin
                        cur_state <= HALT;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader (PRESCALE=4 and PRESCALE=1).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_prog_loader;
    import lib_cpu::*;

    localparam int P4 = 4;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       run_en = 1'b0;
    logic       step = 1'b0;
    logic [3:0] cpu_addr = 4'h0;

    logic       wr_ready, cpu_n_reset, cpu_tick, load_done;
    logic [7:0] cpu_data;
    logic [1:0] state;

    logic       wr_ready1, cpu_n_reset1, cpu_tick1, load_done1;
    logic [7:0] cpu_data1;
    logic [1:0] state1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mem [16];
    logic [7:0] prog    [16];

    always #5 clk = ~clk;

    prog_loader #(.PRESCALE(P4)) dut (
        .clk(clk), .n_reset(n_reset), .load_start(load_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .run_en(run_en), .step(step), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_n_reset(cpu_n_reset), .cpu_tick(cpu_tick), .load_done(load_done),
        .state(state)
    );

    prog_loader #(.PRESCALE(1)) dut1 (
        .clk(clk), .n_reset(n_reset), .load_start(load_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready1),
        .run_en(run_en), .step(step), .cpu_addr(cpu_addr), .cpu_data(cpu_data1),
        .cpu_n_reset(cpu_n_reset1), .cpu_tick(cpu_tick1), .load_done(load_done1),
        .state(state1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic verify_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            cpu_addr = 4'(a);
            #1;
            check(tag, {24'd0, cpu_data}, {24'd0, exp_mem[a]});
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        #1;
        check("wr_ready_on_restart", {31'd0, wr_ready}, 32'd0);
        cycle();
        check("load_entry_state", {30'd0, state}, {30'd0, LOAD});
        check("load_entry_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("load_entry_tick", {31'd0, cpu_tick}, 32'd0);
        load_start = 1'b0;
    endtask

    // Stream prog[] into the memory; gap_mode 0 drops valid every third cycle
    task automatic load_program(input int gap_mode);
        int  idx = 0;
        int  n = 0;
        int  dones = 0;
        logic v;
        while (idx < 16 && n < 200) begin
            v = (gap_mode == 0) ? ((n % 3) != 2) : ($urandom_range(0, 3) != 0);
            wr_valid = v;
            wr_data  = prog[idx];
            step     = 1'($urandom_range(0, 1));
            #1;
            check("wr_ready_in_load", {31'd0, wr_ready}, 32'd1);
            cycle();
            n++;
            if (v) begin
                exp_mem[idx] = prog[idx];
                idx++;
            end
            if (load_done) dones++;
            if (v && idx == 16) begin
                check("load_done_pulse", {31'd0, load_done}, 32'd1);
                check("load_end_state", {30'd0, state}, {30'd0, HALT});
                check("load_end_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd1);
            end else begin
                check("load_mid_state", {30'd0, state}, {30'd0, LOAD});
                check("load_mid_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
                check("load_mid_tick", {31'd0, cpu_tick}, 32'd0);
            end
        end
        wr_valid = 1'b0;
        step     = 1'b0;
        if (idx < 16) check("load_timeout", 32'(idx), 32'd16);
        cycle();
        if (load_done) dones++;
        check("load_done_count", 32'(dones), 32'd1);
        check("post_load_state", {30'd0, state}, {30'd0, HALT});
    endtask

    function automatic logic exp_tick(input int r, input int len, input int p);
        return (r >= 1 + p) && (((r - 1) % p) == 0) && (r <= len + 1);
    endfunction

    // run_en high for len cycles; compare ticks against the tick schedule
    task automatic run_window(input int len);
        run_en = 1'b1;
        for (int r = 1; r <= len + 6; r++) begin
            cycle();
            check("run_tick_p4", {31'd0, cpu_tick}, {31'd0, exp_tick(r, len, P4)});
            check("run_tick_p1", {31'd0, cpu_tick1}, {31'd0, exp_tick(r, len, 1)});
            check("run_state", {30'd0, state}, (r <= len) ? {30'd0, RUN} : {30'd0, HALT});
            if (r == len) run_en = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // ---- Reset state ----
        repeat (3) cycle();
        check("rst_state", {30'd0, state}, {30'd0, HALT});
        check("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("rst_tick", {31'd0, cpu_tick}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        verify_mem("rst_mem");
        cycle();
        n_reset = 1'b1;
        repeat (3) cycle();
        check("idle_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("idle_state", {30'd0, state}, {30'd0, HALT});

        // ---- Three single steps from power-on ----
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            cycle();
            check("step_tick", {31'd0, cpu_tick}, 32'd1);
            check("step_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd1);
            check("step_state", {30'd0, state}, {30'd0, STEP});
            step = 1'b0;
            for (int k = 1; k < 5; k++) begin
                cycle();
                check("step_quiet_tick", {31'd0, cpu_tick}, 32'd0);
                check("step_back_halt", {30'd0, state}, {30'd0, HALT});
            end
        end

        // ---- Load 0x30..0x3F with periodic gaps ----
        for (int i = 0; i < 16; i++) prog[i] = 8'(8'h30 + i);
        start_load();
        load_program(0);
        cpu_addr = 4'd5;
        #1;
        check("mem_addr5", {24'd0, cpu_data}, 32'h35);
        verify_mem("mem_after_load1");

        // ---- run_en and step together: RUN wins ----
        run_en = 1'b1;
        step   = 1'b1;
        cycle();
        check("run_vs_step_state", {30'd0, state}, {30'd0, RUN});
        check("run_vs_step_tick", {31'd0, cpu_tick}, 32'd0);
        run_en = 1'b0;
        step   = 1'b0;
        cycle();
        check("run_vs_step_exit", {30'd0, state}, {30'd0, HALT});
        repeat (3) cycle();

        // ---- Free run windows: fixed 10 then random lengths ----
        run_window(10);
        run_window(int'($urandom_range(3, 20)));
        run_window(int'($urandom_range(3, 20)));

        // ---- step ignored in RUN, load_start in RUN with a byte offered ----
        run_en = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            step = 1'($urandom_range(0, 1));
            cycle();
            check("run2_state", {30'd0, state}, {30'd0, RUN});
            check("run2_tick", {31'd0, cpu_tick}, 32'd0);
        end
        step       = 1'b0;
        load_start = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 8'hAA;
        cpu_addr   = 4'd0;
        #1;
        check("restart_wr_ready", {31'd0, wr_ready}, 32'd0);
        cycle();
        check("restart_state", {30'd0, state}, {30'd0, LOAD});
        check("restart_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("restart_tick", {31'd0, cpu_tick}, 32'd0);
        check("restart_no_write", {24'd0, cpu_data}, {24'd0, exp_mem[0]});
        load_start = 1'b0;
        wr_valid   = 1'b0;
        run_en     = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        load_program(1);
        verify_mem("mem_after_reload");

        // ---- Reset in the middle of a load ----
        start_load();
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom_range(1, 255));
            cycle();
        end
        wr_valid = 1'b0;
        n_reset  = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        check("midrst_state", {30'd0, state}, {30'd0, HALT});
        check("midrst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        verify_mem("midrst_mem");
        cycle();
        n_reset = 1'b1;
        cycle();
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        start_load();
        load_program(1);
        verify_mem("mem_after_rst_reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
